// File: rtl/fc_pkg.sv
// Shared state encoding, widths and sign-magnitude arithmetic for the Float8 FC sequencer.
package fc_pkg;

  localparam int unsigned FLOAT8_W = 8;
  localparam int unsigned SUM_W    = 15;
  localparam int unsigned ROW_W    = 8;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_BREQ  = 4'd1,
    S_BGET  = 4'd2,
    S_RREQ  = 4'd3,
    S_RISS  = 4'd4,
    S_MWAIT = 4'd5,
    S_ADD   = 4'd6,
    S_WR    = 4'd7,
    S_DONE  = 4'd8
  } fc_state_e;

  // Float8Adder datapath: sign-magnitude add, returns {overflow, sum}.
  // Magnitude overflow saturates; a zero result keeps the sign of operand a.
  function automatic logic [SUM_W:0] float8_add(input logic [SUM_W-1:0] a,
                                                input logic [SUM_W-1:0] b);
    logic [SUM_W-2:0] ma, mb, mag;
    logic [SUM_W-1:0] tot;
    logic             sgn, ovf;
    ma  = a[SUM_W-2:0];
    mb  = b[SUM_W-2:0];
    ovf = 1'b0;
    tot = '0;
    if (a[SUM_W-1] == b[SUM_W-1]) begin
      tot = {1'b0, ma} + {1'b0, mb};
      sgn = a[SUM_W-1];
      ovf = tot[SUM_W-1];
      mag = ovf ? '1 : tot[SUM_W-2:0];
    end else if (ma >= mb) begin
      sgn = a[SUM_W-1];
      mag = ma - mb;
    end else begin
      sgn = b[SUM_W-1];
      mag = mb - ma;
    end
    return {ovf, sgn, mag};
  endfunction

  // Strict a > b on sign-magnitude bytes; -0 and +0 compare equal.
  function automatic logic sm_gt(input logic [FLOAT8_W-1:0] a,
                                 input logic [FLOAT8_W-1:0] b);
    logic a_neg, b_neg, gt;
    a_neg = a[FLOAT8_W-1] && (a[FLOAT8_W-2:0] != '0);
    b_neg = b[FLOAT8_W-1] && (b[FLOAT8_W-2:0] != '0);
    if (!a_neg && !b_neg)   gt = a[FLOAT8_W-2:0] > b[FLOAT8_W-2:0];
    else if (a_neg != b_neg) gt = b_neg;
    else                     gt = a[FLOAT8_W-2:0] < b[FLOAT8_W-2:0];
    return gt;
  endfunction

endpackage

// File: rtl/fc_argmax_tracker.sv
// Running argmax over result bytes: loads on row 0, replaces only on strictly greater.
module fc_argmax_tracker
  import fc_pkg::*;
(
  input  logic                clk,
  input  logic                iRst_n,
  input  logic                clr,
  input  logic                upd,
  input  logic                first,
  input  logic [ROW_W-1:0]    idx,
  input  logic [FLOAT8_W-1:0] val,
  output logic [7:0]          oClass
);

  logic [FLOAT8_W-1:0] max_q;

  always_ff @(posedge clk) begin
    if (!iRst_n) begin
      max_q  <= '0;
      oClass <= '0;
    end else if (clr) begin
      max_q  <= '0;
      oClass <= '0;
    end else if (upd && (first || sm_gt(val, max_q))) begin
      max_q  <= val;
      oClass <= idx;
    end
  end

endmodule

// File: rtl/fc_layer_seq.sv
// Fully-connected layer sequencer: bias fetch, per-row weight fetch, MAC, bias add, ReLU, pack.
// Optional running argmax on oClass when FC_ARGMAX_EN is defined.
module fc_layer_seq
  import fc_pkg::*;
#(
  parameter int unsigned       N_OUT   = 10,
  parameter int unsigned       VEC_W   = 128,
  parameter int unsigned       ROM_AW  = 11,
  parameter logic [ROM_AW-1:0] W_BASE  = 11'h000,
  parameter logic [ROM_AW-1:0] B_BASE  = 11'h200,
  parameter int unsigned       MAC_LAT = 1,
  parameter int unsigned       RELU    = 1
) (
  input  logic                   clk,
  input  logic                   iRst_n,
  input  logic                   start,
  input  logic [VEC_W*8-1:0]     data_from_rom,
  input  logic [VEC_W*8-1:0]     data_from_ram,
  input  logic [SUM_W-1:0]       data_from_MultAdder,
  input  logic                   overflow_from_MultAdder,
  output logic [ROM_AW-1:0]      addr_to_rom,
  output logic [VEC_W*8-1:0]     opr1_to_MultAdder,
  output logic [VEC_W*8-1:0]     opr2_to_MultAdder,
  output logic [N_OUT*8-1:0]     data_to_ram,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow,
  output logic [7:0]             oClass
);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(N_OUT - 1);

  fc_state_e               state;
  logic [ROW_W-1:0]        row;
  logic [7:0]              wcnt;
  logic [N_OUT*8-1:0]      bias_q;
  logic [SUM_W-1:0]        add_a, add_b;
  logic [SUM_W-1:0]        sum;
  logic                    sum_ovf;
  logic [FLOAT8_W-1:0]     bias_sel;
  logic [FLOAT8_W-1:0]     res_byte;
  logic                    accept;
  logic                    wr_en;

  assign accept = start && (state == S_IDLE || state == S_DONE);
  assign wr_en  = (state == S_WR);

  always_comb begin
    bias_sel = '0;
    for (int unsigned i = 0; i < N_OUT; i++) begin
      if (row == ROW_W'(i)) bias_sel = bias_q[i*FLOAT8_W +: FLOAT8_W];
    end
  end

  always_comb begin
    {sum_ovf, sum} = float8_add(add_a, add_b);
    res_byte = sum[SUM_W-1 -: FLOAT8_W];
    if (RELU != 0 && sum[SUM_W-1] && (sum[SUM_W-2:0] != '0)) res_byte = '0;
  end

  // addr_to_rom is loaded on entry to BREQ/RREQ so the synchronous ROM returns
  // the word during the following BGET/RISS cycle.
  always_ff @(posedge clk) begin
    if (!iRst_n) begin
      state             <= S_IDLE;
      addr_to_rom       <= '0;
      opr1_to_MultAdder <= '0;
      opr2_to_MultAdder <= '0;
      data_to_ram       <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      overflow          <= 1'b0;
      row               <= '0;
      wcnt              <= '0;
      bias_q            <= '0;
      add_a             <= '0;
      add_b             <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            state       <= S_BREQ;
            addr_to_rom <= B_BASE;
            busy        <= 1'b1;
            done        <= 1'b0;
            overflow    <= 1'b0;
            data_to_ram <= '0;
          end
        end
        S_BREQ: state <= S_BGET;
        S_BGET: begin
          bias_q      <= data_from_rom[N_OUT*8-1:0];
          row         <= '0;
          addr_to_rom <= W_BASE;
          state       <= S_RREQ;
        end
        S_RREQ: state <= S_RISS;
        S_RISS: begin
          opr1_to_MultAdder <= data_from_ram;
          opr2_to_MultAdder <= data_from_rom;
          wcnt              <= 8'(MAC_LAT - 1);
          state             <= S_MWAIT;
        end
        S_MWAIT: begin
          if (wcnt == '0) state <= S_ADD;
          else            wcnt  <= wcnt - 8'd1;
        end
        S_ADD: begin
          add_a    <= {bias_sel, 7'b0};
          add_b    <= data_from_MultAdder;
          overflow <= overflow | overflow_from_MultAdder;
          state    <= S_WR;
        end
        S_WR: begin
          overflow <= overflow | sum_ovf;
          for (int unsigned i = 0; i < N_OUT; i++) begin
            if (row == ROW_W'(i)) data_to_ram[i*FLOAT8_W +: FLOAT8_W] <= res_byte;
          end
          row <= row + 8'd1;
          if (row == LAST_ROW) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            addr_to_rom <= W_BASE + ROM_AW'(row + 8'd1);
            state       <= S_RREQ;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef FC_ARGMAX_EN
  fc_argmax_tracker u_argmax (
    .clk    (clk),
    .iRst_n (iRst_n),
    .clr    (accept),
    .upd    (wr_en),
    .first  (row == '0),
    .idx    (row),
    .val    (res_byte),
    .oClass (oClass)
  );
`else
  assign oClass = '0;
`endif

endmodule

// File: tb/tb_fc_layer_seq.sv
// Scoreboard bench: a default instance and a 3-row / 3-cycle-MAC / no-ReLU instance.
// oClass expectations depend on FC_ARGMAX_EN.
`timescale 1ns/1ps
module tb_fc_layer_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, start_a, start_b;
  logic [1023:0] rom_a, rom_b, ram_vec;
  logic [15:0]   mac_a, mac_b1, mac_b2, mac_b3;
  logic [10:0]   addr_a, addr_b;
  logic [1023:0] o1_a, o2_a, o1_b, o2_b;
  logic [79:0]   res_a;
  logic [23:0]   res_b;
  logic          busy_a, done_a, ovf_a, busy_b, done_b, ovf_b;
  logic [7:0]    cls_a, cls_b;

  logic [7:0] bias_mem [128];
  logic [7:0] wt0 [128];
  logic [7:0] wt1 [128];
  logic [7:0] ram0;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [79:0] data;
    logic        ovf;
    logic [7:0]  cls;
    int          done_cyc;
  } exp_t;
  exp_t q[$];

  logic        log_b;
  logic [10:0] last_b;
  logic [10:0] alog[$];

  assign ram_vec = {{127{8'h33}}, ram0};

  fc_layer_seq u_dut_a (
    .clk(clk), .iRst_n(rst_n), .start(start_a),
    .data_from_rom(rom_a), .data_from_ram(ram_vec),
    .data_from_MultAdder(mac_a[14:0]), .overflow_from_MultAdder(mac_a[15]),
    .addr_to_rom(addr_a), .opr1_to_MultAdder(o1_a), .opr2_to_MultAdder(o2_a),
    .data_to_ram(res_a), .busy(busy_a), .done(done_a), .overflow(ovf_a), .oClass(cls_a)
  );

  fc_layer_seq #(.N_OUT(3), .MAC_LAT(3), .RELU(0)) u_dut_b (
    .clk(clk), .iRst_n(rst_n), .start(start_b),
    .data_from_rom(rom_b), .data_from_ram(ram_vec),
    .data_from_MultAdder(mac_b3[14:0]), .overflow_from_MultAdder(mac_b3[15]),
    .addr_to_rom(addr_b), .opr1_to_MultAdder(o1_b), .opr2_to_MultAdder(o2_b),
    .data_to_ram(res_b), .busy(busy_b), .done(done_b), .overflow(ovf_b), .oClass(cls_b)
  );

  function automatic logic [1023:0] rom_word(input logic [10:0] a);
    logic [1023:0] w;
    w = '0;
    if (a == 11'h200) begin
      for (int i = 0; i < 128; i++) w[i*8 +: 8] = bias_mem[i];
    end else if (a < 11'd128) begin
      w[1023:16] = {126{8'hC3}};
      w[15:8]    = wt1[a[6:0]];
      w[7:0]     = wt0[a[6:0]];
    end
    return w;
  endfunction

  // MultAdder stand-in: lane0 of weights XOR lane0 of activations as the sum byte;
  // weight lane1 == FF raises its overflow flag.
  function automatic logic [15:0] mac_fn(input logic [1023:0] o1, input logic [1023:0] o2);
    return {o2[15:8] == 8'hFF, o2[7:0] ^ o1[7:0], 7'b0};
  endfunction

  always @(posedge clk) begin
    rom_a  <= rom_word(addr_a);
    rom_b  <= rom_word(addr_b);
    mac_a  <= mac_fn(o1_a, o2_a);
    mac_b1 <= mac_fn(o1_b, o2_b);
    mac_b2 <= mac_b1;
    mac_b3 <= mac_b2;
  end

  always @(negedge clk) begin
    if (log_b && addr_b !== last_b) begin
      alog.push_back(addr_b);
      last_b = addr_b;
    end
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic build(input int which, output exp_t e);
    int n, relu, best, key, va, vb, s, mg;
    logic sg, ov;
    logic [7:0] byt;
    logic [14:0] a, b;
    n = which ? 3 : 10;
    relu = which ? 0 : 1;
    e.data = '0; e.ovf = 1'b0; e.cls = '0; e.done_cyc = 0; best = 0;
    for (int r = 0; r < n; r++) begin
      a  = {bias_mem[r], 7'b0};
      b  = {wt0[r] ^ ram0, 7'b0};
      va = a[14] ? -int'(a[13:0]) : int'(a[13:0]);
      vb = b[14] ? -int'(b[13:0]) : int'(b[13:0]);
      s  = va + vb;
      ov = 1'b0;
      if (s > 0)      begin sg = 1'b0; mg = s;  end
      else if (s < 0) begin sg = 1'b1; mg = -s; end
      else            begin sg = a[14]; mg = 0; end
      if (mg > 16383) begin ov = 1'b1; mg = 16383; end
      byt = {sg, 7'(mg / 128)};
      if (relu != 0 && sg && mg != 0) byt = 8'h00;
      e.data[r*8 +: 8] = byt;
      e.ovf = e.ovf | ov | (wt1[r] == 8'hFF);
      key = byt[7] ? -int'(byt[6:0]) : int'(byt[6:0]);
      if (r == 0 || key > best) begin
        best = key;
`ifdef FC_ARGMAX_EN
        e.cls = 8'(r);
`endif
      end
    end
  endtask

  task automatic kick(input int which, input bit push);
    exp_t e;
    @(posedge clk); #1;
    if (which == 0) start_a = 1'b1; else start_b = 1'b1;
    if (push) begin
      build(which, e);
      e.done_cyc = cyc + 3 + (which ? 3 * (4 + 3) : 10 * (4 + 1));
      q.push_back(e);
    end
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
    chk("busy_after_start", which ? busy_b : busy_a, 1'b1);
    chk("done_cleared", which ? done_b : done_a, 1'b0);
  endtask

  task automatic wait_done(input int which);
    exp_t e;
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(posedge clk); #1;
      seen = which ? done_b : done_a;
    end
    chk("done_seen", seen, 1'b1);
    chk("sb_depth", q.size(), 1);
    if (q.size() == 0) return;
    e = q.pop_front();
    if (seen) begin
      chk("done_cycle", cyc, e.done_cyc);
      chk("data_to_ram", which ? {56'b0, res_b} : res_a, e.data);
      chk("overflow", which ? ovf_b : ovf_a, e.ovf);
      chk("oClass", which ? cls_b : cls_a, e.cls);
      chk("busy_in_done", which ? busy_b : busy_a, 1'b0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] exp_addr [4];
    exp_addr = '{11'h200, 11'h000, 11'h001, 11'h002};
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
    log_b = 1'b0; last_b = '0; ram0 = '0;
    for (int i = 0; i < 128; i++) begin
      bias_mem[i] = 8'h25; wt0[i] = '0; wt1[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_addr", addr_a, 11'h000);
    chk("rst_data", res_a, 80'h0);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_done", done_a, 1'b0);
    chk("rst_ovf", ovf_a, 1'b0);
    chk("rst_class", cls_a, 8'h00);
    chk("rst_opr", |{o1_a, o2_a}, 1'b0);
    rst_n = 1'b1;

    // Zero weights, uniform bias
    kick(0, 1); wait_done(0);

    // ReLU on negative bias, negative zero passes
    bias_mem[3] = 8'hA5; bias_mem[5] = 8'h80;
    kick(0, 1); wait_done(0);

    // MultAdder overflow on row 4, sticky then cleared by the next start
    bias_mem[3] = 8'h25; bias_mem[5] = 8'h25; wt1[4] = 8'hFF;
    kick(0, 1); wait_done(0);
    repeat (3) @(posedge clk);
    #1;
    chk("overflow_hold", ovf_a, 1'b1);
    wt1[4] = 8'h00;
    kick(0, 1);
    chk("overflow_cleared", ovf_a, 1'b0);
    wait_done(0);

    // Argmax tie keeps the lower index
    for (int i = 0; i < 128; i++) bias_mem[i] = 8'h10;
    bias_mem[7] = 8'h5A; bias_mem[2] = 8'h5A;
    kick(0, 1); wait_done(0);

    // Small instance: negatives without ReLU, address order, starts while busy
    bias_mem[0] = 8'hA5; bias_mem[1] = 8'h90; bias_mem[2] = 8'hC0;
    last_b = addr_b; log_b = 1'b1;
    kick(1, 1);
    repeat (4) @(posedge clk);
    #1; start_b = 1'b1;
    @(posedge clk); #1; start_b = 1'b0;
    chk("busy_ignored_start", busy_b, 1'b1);
    repeat (6) @(posedge clk);
    #1; start_b = 1'b1;
    @(posedge clk); #1; start_b = 1'b0;
    wait_done(1);
    log_b = 1'b0;
    chk("addr_seq_len", alog.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("addr_seq", (i < alog.size()) ? alog[i] : 11'h7FF, exp_addr[i]);

    // Random weights/bias with a forced adder saturation on row 6
    for (int k = 0; k < 2; k++) begin
      ram0 = 8'($urandom);
      for (int i = 0; i < 128; i++) begin
        bias_mem[i] = 8'($urandom); wt0[i] = 8'($urandom);
      end
      bias_mem[6] = 8'h7F; wt0[6] = 8'h7F ^ ram0;
      kick(0, 1); wait_done(0);
      kick(1, 1); wait_done(1);
    end

    // Reset during row 5 aborts; a fresh run then completes
    kick(0, 0);
    repeat (28) @(posedge clk);
    #1; rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy", busy_a, 1'b0);
    chk("abort_done", done_a, 1'b0);
    chk("abort_addr", addr_a, 11'h000);
    chk("abort_data", res_a, 80'h0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_done", done_a, 1'b0);
    kick(0, 1); wait_done(0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
